// File: rtl/qduc_pkg.sv
// Shared types and constants for the QDUC transmit path.
package qduc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int ISZ           = 16;
  localparam int DEFAULT_RATIO = 31;  // legacy divide-by-32 cadence
  localparam int CIC_OW        = 31;
  localparam int QDUC_OW       = 14;

endpackage

// File: rtl/qduc_strobe_gen.sv
// Programmable divider: counts 0..period while enabled and flags the wrap (decision) cycle.
module qduc_strobe_gen #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_r;

  assign tick = en && (cnt_r == period);

  // divider count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (clr || tick) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/qduc_tx_sched.sv
// Transmit sample scheduler feeding the QDUC CIC interpolators at a programmable cadence.
// Optional underrun counter output enabled by QDUC_TX_SCHED_UCNT_EN.
module qduc_tx_sched
  import qduc_pkg::*;
#(
  parameter int ISZ       = qduc_pkg::ISZ,
  parameter int RATIO_W   = 6,
  parameter int FLUSH_LEN = 8
`ifdef QDUC_TX_SCHED_UCNT_EN
  ,
  parameter int UCNT_W    = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ISZ-1:0]     s_i,
  input  logic [ISZ-1:0]     s_q,
  output logic               duc_stb,
  output logic [ISZ-1:0]     duc_i,
  output logic [ISZ-1:0]     duc_q,
  output logic               busy,
  output logic               underrun
`ifdef QDUC_TX_SCHED_UCNT_EN
  ,
  output logic [UCNT_W-1:0]  underrun_cnt
`endif
);

  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  state_t             state_r, state_nx;
  logic [RATIO_W-1:0] ratio_r;
  logic [ISZ-1:0]     nxt_i_r, nxt_q_r;
  logic               nxt_v_r;
  logic               stop_p_r;
  logic [FW-1:0]      flush_cnt_r;
  logic               duc_stb_r, underrun_r;
  logic [ISZ-1:0]     duc_i_r, duc_q_r;
  logic               tick_s, div_en_s, hs_s, ready_s, accept_start_s, flush_last_s;

  assign div_en_s       = (state_r == RUN) || (state_r == FLUSH);
  assign hs_s           = s_valid && ready_s;
  assign accept_start_s = (state_r == IDLE) && start && !stop;
  assign flush_last_s   = (flush_cnt_r == FW'(FLUSH_LEN - 1));

  qduc_strobe_gen #(.W(RATIO_W)) u_stb (
    .clk    (clk),
    .reset  (reset),
    .en     (div_en_s),
    .clr    (!div_en_s),
    .period (ratio_r),
    .tick   (tick_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // next-state and upstream ready
  always_comb begin
    state_nx = state_r;
    ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop) state_nx = PRIME;
        else                state_nx = IDLE;
      end
      PRIME: begin
        ready_s = 1'b1;
        if (stop)                 state_nx = IDLE;
        else if (s_valid)         state_nx = RUN;
        else                      state_nx = PRIME;
      end
      RUN: begin
        // once stop is pending, nothing more is accepted upstream
        ready_s = !stop_p_r && (!nxt_v_r || tick_s);
        if (tick_s && stop_p_r)   state_nx = FLUSH;
        else                      state_nx = RUN;
      end
      FLUSH: begin
        if (tick_s && flush_last_s) state_nx = IDLE;
        else                        state_nx = FLUSH;
      end
      default: begin
        state_nx = IDLE;
        ready_s  = 1'b0;
      end
    endcase
  end

  // sample holding register, output data/strobe and flush sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      ratio_r     <= {RATIO_W{1'b0}};
      nxt_i_r     <= {ISZ{1'b0}};
      nxt_q_r     <= {ISZ{1'b0}};
      nxt_v_r     <= 1'b0;
      stop_p_r    <= 1'b0;
      flush_cnt_r <= {FW{1'b0}};
      duc_stb_r   <= 1'b0;
      underrun_r  <= 1'b0;
      duc_i_r     <= {ISZ{1'b0}};
      duc_q_r     <= {ISZ{1'b0}};
    end else begin
      duc_stb_r  <= 1'b0;
      underrun_r <= 1'b0;
      case (state_r)
        IDLE: begin
          nxt_v_r     <= 1'b0;
          stop_p_r    <= 1'b0;
          flush_cnt_r <= {FW{1'b0}};
          duc_i_r     <= {ISZ{1'b0}};
          duc_q_r     <= {ISZ{1'b0}};
          if (accept_start_s) begin
            ratio_r <= (ratio == {RATIO_W{1'b0}}) ? {{(RATIO_W-1){1'b0}}, 1'b1} : ratio;
          end
        end
        PRIME: begin
          if (stop) begin
            nxt_v_r <= 1'b0;
          end else if (hs_s) begin
            nxt_i_r <= s_i;
            nxt_q_r <= s_q;
            nxt_v_r <= 1'b1;
          end
        end
        RUN: begin
          stop_p_r    <= stop_p_r || stop;
          flush_cnt_r <= {FW{1'b0}};
          if (tick_s) begin
            duc_stb_r  <= 1'b1;
            underrun_r <= !nxt_v_r;
            duc_i_r    <= nxt_v_r ? nxt_i_r : {ISZ{1'b0}};
            duc_q_r    <= nxt_v_r ? nxt_q_r : {ISZ{1'b0}};
          end
          if (hs_s) begin
            nxt_i_r <= s_i;
            nxt_q_r <= s_q;
            nxt_v_r <= 1'b1;
          end else if (tick_s) begin
            nxt_v_r <= 1'b0;
          end
        end
        FLUSH: begin
          nxt_v_r <= 1'b0;
          if (tick_s) begin
            duc_stb_r   <= 1'b1;
            duc_i_r     <= {ISZ{1'b0}};
            duc_q_r     <= {ISZ{1'b0}};
            flush_cnt_r <= flush_cnt_r + {{(FW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          nxt_v_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef QDUC_TX_SCHED_UCNT_EN
  logic [UCNT_W-1:0] ucnt_r;

  // saturating underrun counter, updated on the same edge that raises underrun
  always_ff @(posedge clk) begin
    if (reset || accept_start_s) begin
      ucnt_r <= {UCNT_W{1'b0}};
    end else if ((state_r == RUN) && tick_s && !nxt_v_r && (ucnt_r != {UCNT_W{1'b1}})) begin
      ucnt_r <= ucnt_r + {{(UCNT_W-1){1'b0}}, 1'b1};
    end else begin
      ucnt_r <= ucnt_r;
    end
  end

  assign underrun_cnt = ucnt_r;
`endif

  assign s_ready  = ready_s;
  assign busy     = (state_r != IDLE);
  assign duc_stb  = duc_stb_r;
  assign underrun = underrun_r;
  assign duc_i    = duc_i_r;
  assign duc_q    = duc_q_r;

endmodule

// File: tb/tb_qduc_tx_sched.sv
// Directed, table-driven bench for qduc_tx_sched (optionally with QDUC_TX_SCHED_UCNT_EN).
module tb_qduc_tx_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, s_valid = 1'b0;
  logic [5:0]  ratio = 6'd0;
  logic [15:0] s_i = 16'd0, s_q = 16'd0;
  logic        s_ready, duc_stb, busy, underrun;
  logic [15:0] duc_i, duc_q;
`ifdef QDUC_TX_SCHED_UCNT_EN
  logic [1:0]  underrun_cnt;
`endif

  qduc_tx_sched #(
    .ISZ(16), .RATIO_W(6), .FLUSH_LEN(8)
`ifdef QDUC_TX_SCHED_UCNT_EN
    , .UCNT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ratio(ratio),
    .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
    .duc_stb(duc_stb), .duc_i(duc_i), .duc_q(duc_q), .busy(busy), .underrun(underrun)
`ifdef QDUC_TX_SCHED_UCNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ratio;
    int          r_eff;
    logic [15:0] smp [4];
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0;
  int hs_n, hs_first, st_n, un_n;
  int st_cyc [32];
  logic [15:0] st_i [32], st_q [32];
  logic        st_u [32];
  logic [15:0] samp [8];
  logic [15:0] exp_i [20], exp_q [20];
  logic        exp_u [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // observe one cycle at the falling edge, then move to just after the next rising edge
  task automatic step();
    @(negedge clk);
    if (s_valid && s_ready) begin
      if (hs_n == 0) hs_first = cyc;
      hs_n++;
    end
    if (duc_stb && st_n < 32) begin
      st_cyc[st_n] = cyc; st_i[st_n] = duc_i; st_q[st_n] = duc_q; st_u[st_n] = underrun;
      st_n++;
    end
    if (underrun) un_n++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mon();
    hs_n = 0; hs_first = 0; st_n = 0; un_n = 0;
  endtask

  task automatic drive_data();
    s_i = samp[hs_n < 8 ? hs_n : 7];
    s_q = samp[hs_n < 8 ? hs_n : 7] ^ 16'h5A5A;
  endtask

  task automatic check_run(input string tag, input int r_eff, input int n_exp);
    chk({tag, "_strobes"}, 32'(st_n), 32'(n_exp));
    for (int k = 0; k < n_exp && k < st_n; k++) begin
      if (k == 0) chk({tag, "_first_lat"}, 32'(st_cyc[0] - hs_first), 32'(r_eff + 2));
      else        chk({tag, "_period"}, 32'(st_cyc[k] - st_cyc[k-1]), 32'(r_eff + 1));
      chk({tag, "_duc_i"}, {16'd0, st_i[k]}, {16'd0, exp_i[k]});
      chk({tag, "_duc_q"}, {16'd0, st_q[k]}, {16'd0, exp_q[k]});
      chk({tag, "_underrun"}, {31'd0, st_u[k]}, {31'd0, exp_u[k]});
    end
  endtask

  // stop in the next cycle with valid low, then hold valid high and drain until idle
  task automatic stop_and_drain(input string tag, input int hs_exp, input int bound);
    int g;
    stop = 1'b1; s_valid = 1'b0;
    step();
    stop = 1'b0; s_valid = 1'b1; drive_data();
    g = 0;
    while (busy && g < bound) begin step(); g++; end
    if (busy) chk({tag, "_drain_timeout"}, 32'd1, 32'd0);
    repeat (3) step();
    s_valid = 1'b0;
    chk({tag, "_hs_after_stop"}, 32'(hs_n), 32'(hs_exp));
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready_end"}, {31'd0, s_ready}, 32'd0);
  endtask

  initial begin
    vec_t vecs [5];
    int g, snap_st, snap_hs;
    vecs[0] = '{ratio: 6'd31, r_eff: 31, smp: '{16'd1, 16'd2, 16'd3, 16'd4}};
    vecs[1] = '{ratio: 6'd0,  r_eff: 1,  smp: '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF}};
    vecs[2] = '{ratio: 6'd3,  r_eff: 3,  smp: '{16'h1111, 16'h2222, 16'h3333, 16'h7FFF}};
    vecs[3] = '{ratio: 6'd1,  r_eff: 1,  smp: '{16'hA5A5, 16'h0F0F, 16'h00FF, 16'hFF00}};
    vecs[4] = '{ratio: 6'd63, r_eff: 63, smp: '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}};

    clear_mon();
    repeat (3) step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, s_ready}, 32'd0);
    chk("reset_stb", {31'd0, duc_stb}, 32'd0);
    chk("reset_duc_i", {16'd0, duc_i}, 32'd0);
    chk("reset_duc_q", {16'd0, duc_q}, 32'd0);
    chk("reset_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    step();

    // table: continuous stream of four samples, stop, flush
    for (int e = 0; e < 5; e++) begin
      clear_mon();
      for (int k = 0; k < 4; k++) samp[k] = vecs[e].smp[k];
      for (int k = 4; k < 8; k++) samp[k] = 16'h1234;
      for (int k = 0; k < 20; k++) begin
        exp_i[k] = (k < 4) ? samp[k] : 16'd0;
        exp_q[k] = (k < 4) ? (samp[k] ^ 16'h5A5A) : 16'd0;
        exp_u[k] = 1'b0;
      end
      start = 1'b1; ratio = vecs[e].ratio; s_valid = 1'b1; drive_data();
      step();
      start = 1'b0; ratio = ~vecs[e].ratio;
      g = 0;
      while (hs_n < 4 && g < 400) begin drive_data(); step(); g++; end
      if (hs_n < 4) chk("tbl_hs_timeout", 32'(hs_n), 32'd4);
      stop_and_drain("tbl", 4, 12 * (vecs[e].r_eff + 1) + 20);
      check_run("tbl", vecs[e].r_eff, 12);
    end

    // underrun: valid dropped for 8 cycles starting on a decision cycle
    clear_mon();
    for (int k = 0; k < 8; k++) samp[k] = 16'd10 + 16'(k);
    for (int k = 0; k < 20; k++) begin exp_i[k] = 16'd0; exp_q[k] = 16'd0; exp_u[k] = 1'b0; end
    for (int k = 0; k < 3; k++) begin exp_i[k] = samp[k]; exp_q[k] = samp[k] ^ 16'h5A5A; end
    exp_u[3] = 1'b1; exp_u[4] = 1'b1;
    for (int k = 3; k < 6; k++) begin exp_i[k+2] = samp[k]; exp_q[k+2] = samp[k] ^ 16'h5A5A; end
    start = 1'b1; ratio = 6'd3; s_valid = 1'b1; drive_data();
    step();
    start = 1'b0;
    g = 0;
    while (hs_n < 6 && g < 200) begin
      s_valid = !(hs_n > 0 && (cyc - hs_first) >= 12 && (cyc - hs_first) <= 19);
      drive_data(); step(); g++;
    end
    if (hs_n < 6) chk("ur_hs_timeout", 32'(hs_n), 32'd6);
    stop_and_drain("ur", 6, 100);
    check_run("ur", 3, 16);
    chk("ur_pulses", 32'(un_n), 32'd2);

    // start and stop together in IDLE
    clear_mon();
    start = 1'b1; stop = 1'b1; ratio = 6'd3;
    step();
    start = 1'b0; stop = 1'b0;
    repeat (3) step();
    chk("startstop_busy", {31'd0, busy}, 32'd0);
    chk("startstop_ready", {31'd0, s_ready}, 32'd0);

    // reset while running
    clear_mon();
    for (int k = 0; k < 8; k++) samp[k] = 16'h0100 + 16'(k);
    start = 1'b1; ratio = 6'd3; s_valid = 1'b1; drive_data();
    step();
    start = 1'b0;
    g = 0;
    while (st_n < 2 && g < 100) begin drive_data(); step(); g++; end
    chk("rst_prestrobes", 32'(st_n), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    snap_st = st_n; snap_hs = hs_n;
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stb", {31'd0, duc_stb}, 32'd0);
    chk("rst_duc_i", {16'd0, duc_i}, 32'd0);
    chk("rst_duc_q", {16'd0, duc_q}, 32'd0);
    repeat (10) step();
    chk("rst_no_strobe", 32'(st_n), 32'(snap_st));
    chk("rst_no_hs", 32'(hs_n), 32'(snap_hs));
    s_valid = 1'b0;

`ifdef QDUC_TX_SCHED_UCNT_EN
    // saturating underrun counter
    clear_mon();
    start = 1'b1; ratio = 6'd1; s_valid = 1'b1; drive_data();
    step();
    start = 1'b0;
    g = 0;
    while (hs_n < 1 && g < 20) begin step(); g++; end
    s_valid = 1'b0;
    g = 0;
    while (un_n < 5 && g < 100) begin step(); g++; end
    chk("ucnt_pulses", 32'(un_n), 32'd5);
    step();
    chk("ucnt_sat", {30'd0, underrun_cnt}, 32'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    g = 0;
    while (busy && g < 100) begin step(); g++; end
    chk("ucnt_hold_idle", {30'd0, underrun_cnt}, 32'd3);
    start = 1'b1; ratio = 6'd1;
    step();
    start = 1'b0; stop = 1'b1;
    step();
    chk("ucnt_clear", {30'd0, underrun_cnt}, 32'd0);
    stop = 1'b0;
    repeat (3) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qduc_tx_sched.md
Name: qduc_tx_sched

Overview:
Transmit sample scheduler placed in front of the quadrature upconverter (QDUC). It pulls I/Q words from an upstream valid/ready stream and issues them to the CIC interpolators at a programmable interpolation cadence. On underrun it inserts zero samples. On stop it runs a zero-sample flush so the CIC integrators drain. It replaces the fixed divide-by-32 strobe with a sequenced, start/stop-controlled strobe.

Parameters:
ISZ, 16, I/Q sample width (matches QDUC input word size)
RATIO_W, 6, width of the ratio control field
FLUSH_LEN, 8, number of zero strobes issued after stop
UCNT_W, 16, underrun counter width (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin transmission
stop  in  1  one-cycle request to end transmission
ratio  in  RATIO_W  strobe period minus 1; sampled on accepted start
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream sample accept
s_i  in  ISZ  upstream in-phase sample (signed)
s_q  in  ISZ  upstream quadrature sample (signed)
duc_stb  out  1  one-cycle CIC input strobe
duc_i  out  ISZ  in-phase sample to CIC, stable between strobes
duc_q  out  ISZ  quadrature sample to CIC, stable between strobes
busy  out  1  high when state is not IDLE
underrun  out  1  pulse coincident with duc_stb when a zero is inserted

Behaviour:
- Reset values: state IDLE; divider count 0; next-sample valid (nxt_v) 0; all outputs 0.
- States:
  - IDLE: s_ready=0, duc_stb=0.
    - start && !stop: latch ratio_r = max(ratio,1), giving a minimum strobe period of 2 cycles; go to PRIME.
    - start && stop together: stay in IDLE (stop wins).
    - stop alone: ignored.
  - PRIME: s_ready=1.
    - First handshake (s_valid && s_ready) in cycle t loads nxt and sets nxt_v=1; state is RUN from t+1 with cnt=0.
    - stop in PRIME: return to IDLE with nxt_v=0.
  - RUN: cnt counts 0..ratio_r, then wraps to 0. A decision cycle occurs at cnt==ratio_r.
    - On a decision cycle, duc_i/duc_q take nxt (or 0 if nxt_v=0) and nxt_v clears. The registered duc_stb is high the following cycle, aligned with the new data.
    - First strobe appears at cycle t+ratio_r+2. Strobe period thereafter is ratio_r+1 cycles.
    - s_ready = !nxt_v || decision cycle. A handshake on a decision cycle refills nxt and keeps nxt_v=1.
    - underrun pulses with duc_stb when nxt_v=0 at the decision cycle.
    - stop is latched (stop_p). At the next decision cycle the pending nxt, if any, is emitted normally and the state moves to FLUSH; s_ready=0 from the cycle after stop.
  - FLUSH: s_ready=0; same cadence; issue FLUSH_LEN strobes with duc_i=duc_q=0 and no underrun pulses. After the last strobe, go to IDLE with outputs 0.
- start outside IDLE is ignored. Repeated stop while stop_p is set is ignored.
- Reset mid-operation: IDLE on the next edge. Any in-flight sample is dropped; no strobe is emitted.
- No arithmetic on samples: pass-through or zero only.
- ratio changes outside an accepted start have no effect.

Optional Feature:
Macro QDUC_TX_SCHED_UCNT_EN.
- Defined: adds output underrun_cnt [UCNT_W-1:0]. It increments on each underrun pulse, saturates at all-ones, and clears on reset and on accepted start.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package qduc_pkg:
  - state enum (IDLE, PRIME, RUN, FLUSH)
  - ISZ = 16
  - default ratio constant 31 (legacy /32 rate)
  - CIC output width 31 and QDUC output width 14 for shared use
- One sub-module, qduc_strobe_gen: programmable divider with enable, sync clear and decision-cycle output; reused later for the RX-side decimator.

Test Plan:
- ratio=31, start, continuous s_valid with samples 1,2,3 → duc_stb every 32 cycles carrying 1,2,3; first strobe 33 cycles after the first handshake; underrun never asserted.
- ratio=3, s_valid dropped for 8 cycles mid-stream → exactly 2 strobes with duc_i=duc_q=0 and underrun high; stream then resumes in order.
- ratio=0 → treated as 1; strobe period 2 cycles; s_ready accepts back-to-back samples.
- stop during RUN with a pending sample 0x7FFF → 0x7FFF emitted, then FLUSH_LEN=8 zero strobes, then busy low and s_ready low.
- start and stop asserted together in IDLE → busy stays 0; reset asserted in RUN → next cycle busy=0, duc_stb=0, duc_i=0.
- With QDUC_TX_SCHED_UCNT_EN, UCNT_W=2, 5 underruns → underrun_cnt=3 (saturated); a new start clears it to 0.
